// File: rtl/control_in_capture_fifo.sv
// control_in_capture_fifo: captures the LC3 controller-input bundle into a FIFO with overflow drop counting
module control_in_capture_fifo #(
  parameter int INSTR_W = 16,
  parameter int FLAG_W  = 3,
  parameter int DEPTH   = 8,
  parameter int MODE    = 0,
  parameter int CNT_W   = 8,
  localparam int W      = 2 + 3 * INSTR_W + 2 * FLAG_W,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sample_en,
  input  logic               flush,
  input  logic               complete_data,
  input  logic               complete_instr,
  input  logic [INSTR_W-1:0] IR,
  input  logic [FLAG_W-1:0]  NZP,
  input  logic [FLAG_W-1:0]  psr,
  input  logic [INSTR_W-1:0] IR_Exec,
  input  logic [INSTR_W-1:0] IMem_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic [AW:0]        count,
  output logic               full,
  output logic [CNT_W-1:0]   drop_count
);
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  pk, last;
  logic          last_vld, cap, pop, push, drop;
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign pk        = {complete_data, complete_instr, IR, NZP, psr, IR_Exec, IMem_dout};
  assign cap       = sample_en & ((MODE == 0) | !last_vld | (pk != last));
  assign out_valid = count != '0;
  assign full      = count == (AW+1)'(DEPTH);
  assign pop       = out_valid & out_ready;
  assign push      = cap & (!full | pop);
  assign drop      = cap & full & !pop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // pointers, occupancy, change-detect history and saturating drop counter; flush wins over push/pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
      last       <= '0;
      last_vld   <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_vld <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
      if (cap) begin
        last     <= pk;
        last_vld <= 1'b1;
      end
    end
  end

  // storage is unreset; stale entries are masked by out_valid
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= pk;
  end
endmodule

// File: tb/tb_control_in_capture_fifo.sv
// tb_control_in_capture_fifo: scoreboard bench for MODE 0, MODE 1 and narrow drop counter instances
module tb_control_in_capture_fifo;
  logic        clock = 1'b0, reset = 1'b1, flush = 1'b0;
  logic        cd = 1'b1, ci = 1'b0;
  logic [15:0] ir = '0, ire = 16'hABCD, imd = 16'h1234;
  logic [2:0]  nzp = 3'b010, psr = 3'b101;
  logic        se_a = 0, se_b = 0, se_c = 0, rdy_a = 0, rdy_b = 0, rdy_c = 0;
  logic        valid_a, valid_b, valid_c, full_a, full_b, full_c;
  logic [55:0] data_a, data_b, data_c;
  logic [3:0]  count_a, count_b, count_c;
  logic [7:0]  drop_a, drop_b;
  logic [1:0]  drop_c;
  logic [55:0] qa[$], qb[$];
  logic [55:0] pk, lastb;
  logic        lvb, pa, pb, fa, fb;
  int          da, db, dc, cc;
  int          checks = 0, failures = 0;

  always #5 clock = ~clock;
  assign pk = {cd, ci, ir, nzp, psr, ire, imd};

  control_in_capture_fifo u_a (
    .clock(clock), .reset(reset), .sample_en(se_a), .flush(flush),
    .complete_data(cd), .complete_instr(ci), .IR(ir), .NZP(nzp), .psr(psr),
    .IR_Exec(ire), .IMem_dout(imd), .out_valid(valid_a), .out_ready(rdy_a),
    .out_data(data_a), .count(count_a), .full(full_a), .drop_count(drop_a));

  control_in_capture_fifo #(.MODE(1)) u_b (
    .clock(clock), .reset(reset), .sample_en(se_b), .flush(flush),
    .complete_data(cd), .complete_instr(ci), .IR(ir), .NZP(nzp), .psr(psr),
    .IR_Exec(ire), .IMem_dout(imd), .out_valid(valid_b), .out_ready(rdy_b),
    .out_data(data_b), .count(count_b), .full(full_b), .drop_count(drop_b));

  control_in_capture_fifo #(.CNT_W(2)) u_c (
    .clock(clock), .reset(reset), .sample_en(se_c), .flush(flush),
    .complete_data(cd), .complete_instr(ci), .IR(ir), .NZP(nzp), .psr(psr),
    .IR_Exec(ire), .IMem_dout(imd), .out_valid(valid_c), .out_ready(rdy_c),
    .out_data(data_c), .count(count_c), .full(full_c), .drop_count(drop_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard: check state at the negedge, then predict the coming edge from the stable inputs
  always @(negedge clock) begin
    if (reset) begin
      qa.delete(); qb.delete();
      da = 0; db = 0; dc = 0; cc = 0; lvb = 0; lastb = '0;
    end else begin
      chk("a_count", count_a, qa.size()); chk("a_valid", valid_a, qa.size() != 0);
      chk("a_full", full_a, qa.size() == 8); chk("a_drop", drop_a, da);
      chk("b_count", count_b, qb.size()); chk("b_valid", valid_b, qb.size() != 0);
      chk("b_drop", drop_b, db);
      chk("c_count", count_c, cc); chk("c_drop", drop_c, dc);
      pa = qa.size() != 0 && rdy_a;
      pb = qb.size() != 0 && rdy_b;
      if (pa) chk("a_data", data_a, qa[0]);
      if (pb) chk("b_data", data_b, qb[0]);
      if (flush) begin
        qa.delete(); qb.delete(); cc = 0; lvb = 0;
      end else begin
        fa = qa.size() == 8;
        if (pa) void'(qa.pop_front());
        if (se_a) begin
          if (!fa || pa) qa.push_back(pk);
          else if (da != 255) da++;
        end
        fb = qb.size() == 8;
        if (pb) void'(qb.pop_front());
        if (se_b && (!lvb || pk != lastb)) begin
          if (!fb || pb) qb.push_back(pk);
          else if (db != 255) db++;
          lastb = pk; lvb = 1;
        end
        if (se_c) begin
          if (cc < 8) cc++;
          else if (dc != 3) dc++;
        end
      end
    end
  end

  task automatic drain_a();
    rdy_a = 1;
    for (int k = 0; k < 30 && count_a != 0; k++) tick();
    chk("a_drained", count_a, 0);
    rdy_a = 0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk("rst_count", count_a, 0); chk("rst_valid", valid_a, 0); chk("rst_full", full_a, 0);
    chk("rst_drop", drop_a, 0); chk("rst_data", data_a, 0);
    // overflow: 10 samples into 8 entries
    for (int i = 0; i < 10; i++) begin
      ir = 16'h1000 + 16'(i); se_a = 1; tick();
    end
    se_a = 0;
    chk("ovf_count", count_a, 8); chk("ovf_full", full_a, 1); chk("ovf_drop", drop_a, 2);
    chk("ovf_head_ir", data_a[53:38], 16'h1000);
    drain_a();
    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      ir = 16'h2000 + 16'(i); se_a = 1; tick();
    end
    rdy_a = 1; ir = 16'h2008; tick();
    se_a = 0; rdy_a = 0;
    chk("pp_count", count_a, 8); chk("pp_drop", drop_a, 2); chk("pp_head_ir", data_a[53:38], 16'h2001);
    drain_a();
    // MODE 1 change detection
    ir = 16'h5020; se_b = 1;
    repeat (4) tick();
    ir = 16'h5021;
    repeat (3) tick();
    se_b = 0;
    chk("m1_count", count_b, 2); chk("m1_head_ir", data_b[53:38], 16'h5020);
    ir = 16'h5022; se_b = 1; tick();
    chk("m1_count3", count_b, 3);
    flush = 1; tick();
    flush = 0;
    chk("fl_count", count_b, 0); chk("fl_valid", valid_b, 0);
    tick();
    se_b = 0;
    chk("fl_recap", count_b, 1); chk("fl_recap_ir", data_b[53:38], 16'h5022);
    rdy_b = 1; tick(); rdy_b = 0;
    chk("b_drained", count_b, 0);
    // narrow drop counter saturation
    se_c = 1;
    repeat (13) tick();
    se_c = 0;
    chk("sat_drop", drop_c, 3); chk("sat_full", full_c, 1);
    // asynchronous reset mid-stream
    for (int i = 0; i < 9; i++) begin
      ir = 16'h3000 + 16'(i); se_a = 1; tick();
    end
    se_a = 0; rdy_a = 1;
    repeat (3) tick();
    rdy_a = 0;
    chk("pre_count", count_a, 5); chk("pre_drop", drop_a, 3);
    #2 reset = 1;
    #1;
    chk("ar_count", count_a, 0); chk("ar_valid", valid_a, 0); chk("ar_full", full_a, 0);
    chk("ar_drop", drop_a, 0); chk("ar_data", data_a, 0); chk("ar_c_drop", drop_c, 0);
    tick();
    reset = 0;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
